// File: rtl/motor_pkg.sv
// Shared definitions for the motor start-up sequencer.
//   K_PERIOD_W : default width of period/time quantities
//   state_e    : sequencer state codes (IDLE=0 .. BRAKE=4)
package motor_pkg;

   localparam int unsigned K_PERIOD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_RAMP  = 3'd2,
      ST_RUN   = 3'd3,
      ST_BRAKE = 3'd4
   } state_e;

endpackage

// File: rtl/period_timer.sv
// Period timer: emits a one-cycle pulse every max(period,1) enabled cycles.
//   i_load    : restart the count; first pulse lands period cycles after load
//   i_enable  : count while high; counter parks at 0 otherwise
//   i_period  : cycles between pulses (0 treated as 1)
//   o_pulse_c : combinational pulse, registered by the parent
module period_timer #(
   parameter int unsigned K_W = 16
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_load,
   input  logic           i_enable,
   input  logic [K_W-1:0] i_period,
   output logic           o_pulse_c
);

   logic [K_W-1:0] cnt_q, cnt_d;
   logic [K_W-1:0] per_eff_c;

   // Count the cycle of load as 1 so a pulse computed at count==period
   // appears on the registered output exactly period cycles after entry.
   always_comb begin
      per_eff_c = (i_period == '0) ? K_W'(1) : i_period;
      o_pulse_c = i_enable && !i_load && (cnt_q >= per_eff_c);
      cnt_d     = '0;
      if (i_load) begin
         cnt_d = K_W'(1);
      end else if (i_enable) begin
         cnt_d = o_pulse_c ? K_W'(1) : (cnt_q + K_W'(1));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/motor_sequencer.sv
// Motor start-up sequencer: IDLE -> ALIGN -> RAMP -> RUN, with stop and brake.
//   i_start/i_stop/i_brake_req : request levels (brake > stop > start)
//   i_align_time, i_align_power : rotor alignment duration and power
//   i_start_period, i_target_period, i_ramp_dec : open-loop ramp profile
//   i_run_power                 : power during RAMP and RUN
//   o_force_step_*              : pattern generator force interface
//   o_step_trigger, o_power, o_brake : pattern generator drive
//   o_state, o_running          : status
module motor_sequencer #(
   parameter int unsigned K_NSUBSTEPS = 10,
   parameter int unsigned K_PERIOD_W  = motor_pkg::K_PERIOD_W
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_start,
   input  logic                           i_stop,
   input  logic                           i_brake_req,
   input  logic [K_PERIOD_W-1:0]          i_align_time,
   input  logic [K_PERIOD_W-1:0]          i_start_period,
   input  logic [K_PERIOD_W-1:0]          i_target_period,
   input  logic [7:0]                     i_ramp_dec,
   input  logic [$clog2(K_NSUBSTEPS)-1:0] i_align_power,
   input  logic [$clog2(K_NSUBSTEPS)-1:0] i_run_power,
   output logic [2:0]                     o_force_step_value,
   output logic                           o_force_step_trigger,
   output logic [$clog2(K_NSUBSTEPS)-1:0] o_force_substep,
   output logic                           o_step_trigger,
   output logic [$clog2(K_NSUBSTEPS)-1:0] o_power,
   output logic                           o_brake,
   output logic [2:0]                     o_state,
   output logic                           o_running
);

   import motor_pkg::*;

   localparam int unsigned PW = $clog2(K_NSUBSTEPS);
   localparam int unsigned EW = K_PERIOD_W + 8;
   localparam logic [PW-1:0] SUB_LAST = PW'(K_NSUBSTEPS - 1);

   state_e                state_q, state_d;
   logic [K_PERIOD_W-1:0] period_q, period_d;
   logic [K_PERIOD_W-1:0] tgt_q, tgt_d;
   logic [K_PERIOD_W-1:0] align_cnt_q, align_cnt_d;
   logic [PW-1:0]         substep_q, substep_d;
   logic [PW-1:0]         power_q, power_d;
   logic                  force_trig_q, force_trig_d;
   logic                  step_trig_q, step_trig_d;
   logic                  brake_q, brake_d;
   logic                  running_q, running_d;

   logic                  pulse_c, timer_en_c, leave_align_c, align_done_c;
   logic [K_PERIOD_W-1:0] align_eff_c, ramp_next_c;
   logic [7:0]            dec_eff_c;
   logic [EW-1:0]         gap_c;

   // Step cadence generator
   period_timer #(.K_W(K_PERIOD_W)) u_timer (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_load    (leave_align_c),
      .i_enable  (timer_en_c),
      .i_period  (period_q),
      .o_pulse_c (pulse_c)
   );

   // Next ramp period, clamped at the latched target without underflow
   always_comb begin
      dec_eff_c   = (i_ramp_dec == 8'd0) ? 8'd1 : i_ramp_dec;
      gap_c       = EW'(period_q) - EW'(tgt_q);
      ramp_next_c = (gap_c > EW'(dec_eff_c)) ? (period_q - K_PERIOD_W'(dec_eff_c)) : tgt_q;
      align_eff_c = (i_align_time == '0) ? K_PERIOD_W'(1) : i_align_time;
   end

   assign timer_en_c    = (state_q == ST_RAMP) || (state_q == ST_RUN);
   assign align_done_c  = (align_cnt_q >= align_eff_c);
   assign leave_align_c = (state_q == ST_ALIGN) && !i_brake_req && !i_stop && align_done_c;

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      period_d     = period_q;
      tgt_d        = tgt_q;
      align_cnt_d  = '0;
      substep_d    = substep_q;
      power_d      = '0;
      force_trig_d = 1'b0;
      step_trig_d  = 1'b0;
      brake_d      = 1'b0;
      running_d    = 1'b0;

      if (i_brake_req) begin
         state_d = ST_BRAKE;
      end else begin
         case (state_q)
            ST_IDLE:  if (!i_stop && i_start) state_d = ST_ALIGN;
            ST_ALIGN: begin
               if (i_stop)            state_d = ST_IDLE;
               else if (align_done_c) state_d = (i_start_period <= i_target_period) ? ST_RUN : ST_RAMP;
            end
            ST_RAMP: begin
               if (i_stop)                 state_d = ST_IDLE;
               else if (period_q == tgt_q) state_d = ST_RUN;
            end
            ST_RUN:   if (i_stop) state_d = ST_IDLE;
            ST_BRAKE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end

      if (state_d == ST_ALIGN) begin
         align_cnt_d = (state_q == ST_ALIGN) ? (align_cnt_q + K_PERIOD_W'(1)) : K_PERIOD_W'(1);
      end
      force_trig_d = (state_q == ST_IDLE) && (state_d == ST_ALIGN);

      if (leave_align_c) begin
         period_d  = (i_start_period > i_target_period) ? i_start_period : i_target_period;
         tgt_d     = i_target_period;
         substep_d = '0;
      end

      // A state exit suppresses a coincident trigger
      step_trig_d = pulse_c && ((state_d == ST_RAMP) || (state_d == ST_RUN));
      if (step_trig_d) begin
         substep_d = (substep_q == SUB_LAST) ? '0 : (substep_q + PW'(1));
         if ((state_q == ST_RAMP) && (substep_q == SUB_LAST)) period_d = ramp_next_c;
      end

      case (state_d)
         ST_ALIGN:        power_d = i_align_power;
         ST_RAMP, ST_RUN: power_d = i_run_power;
         default:         power_d = '0;
      endcase
      brake_d   = (state_d == ST_BRAKE);
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         period_q     <= '0;
         tgt_q        <= '0;
         align_cnt_q  <= '0;
         substep_q    <= '0;
         power_q      <= '0;
         force_trig_q <= 1'b0;
         step_trig_q  <= 1'b0;
         brake_q      <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         tgt_q        <= tgt_d;
         align_cnt_q  <= align_cnt_d;
         substep_q    <= substep_d;
         power_q      <= power_d;
         force_trig_q <= force_trig_d;
         step_trig_q  <= step_trig_d;
         brake_q      <= brake_d;
         running_q    <= running_d;
      end
   end

   // Alignment always forces commutation step 0, substep 0
   assign o_force_step_value   = 3'd0;
   assign o_force_substep      = '0;
   assign o_force_step_trigger = force_trig_q;
   assign o_step_trigger       = step_trig_q;
   assign o_power              = power_q;
   assign o_brake              = brake_q;
   assign o_state              = state_q;
   assign o_running            = running_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer (K_NSUBSTEPS=10, K_PERIOD_W=16).
module tb_motor_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop, brake;
   logic [15:0] align_t, sp, tp;
   logic [7:0]  dec;
   logic [3:0]  ap, rp;
   logic [2:0]  o_force_step_value;
   logic        o_force_step_trigger;
   logic [3:0]  o_force_substep;
   logic        o_step_trigger;
   logic [3:0]  o_power;
   logic        o_brake;
   logic [2:0]  o_state;
   logic        o_running;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int trig_t[$];

   always #5 clk = ~clk;

   motor_sequencer #(.K_NSUBSTEPS(10), .K_PERIOD_W(16)) dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_start              (start),
      .i_stop               (stop),
      .i_brake_req          (brake),
      .i_align_time         (align_t),
      .i_start_period       (sp),
      .i_target_period      (tp),
      .i_ramp_dec           (dec),
      .i_align_power        (ap),
      .i_run_power          (rp),
      .o_force_step_value   (o_force_step_value),
      .o_force_step_trigger (o_force_step_trigger),
      .o_force_substep      (o_force_substep),
      .o_step_trigger       (o_step_trigger),
      .o_power              (o_power),
      .o_brake              (o_brake),
      .o_state              (o_state),
      .o_running            (o_running)
   );

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // Record absolute cycle numbers of triggers until n are held or budget expires
   task automatic collect(input int n, input int budget);
      int c0;
      c0 = cyc;
      while (trig_t.size() < n && (cyc - c0) < budget) begin
         tick();
         if (o_step_trigger) trig_t.push_back(cyc);
      end
   endtask

   task automatic go_idle();
      start = 0; brake = 0; stop = 1;
      tick();
      stop = 0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 0; start = 0; stop = 0; brake = 0;
      align_t = 16'd5; sp = 16'd20; tp = 16'd8; dec = 8'd4; ap = 4'd3; rp = 4'd7;
      tick(); tick();
      checks++;
      if ({o_state, o_power, o_step_trigger, o_brake, o_running, o_force_step_trigger} !== 13'd0) begin
         failures++;
         $display("FAIL reset_outputs: got state=%0d power=%0d trig=%0b brake=%0b run=%0b ft=%0b expected all 0",
                  o_state, o_power, o_step_trigger, o_brake, o_running, o_force_step_trigger);
      end
      rst_n = 1;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (o_state !== 3'd0 || o_power !== 4'd0) begin
         failures++;
         $display("FAIL idle_after_reset: got state=%0d power=%0d expected 0 0", o_state, o_power);
      end
   endtask

   task automatic test_ramp();
      int n_al, n_ft, bad_pw, bad_tr, bad_fv, entry, prev, d;
      int exp_iv;
      int bad_g[4];
      align_t = 16'd5; sp = 16'd20; tp = 16'd8; dec = 8'd4; ap = 4'd3; rp = 4'd7;
      start = 1;
      tick();
      start = 0;
      n_al = 0; n_ft = 0; bad_pw = 0; bad_tr = 0; bad_fv = 0;
      while (o_state == 3'd1 && n_al < 100) begin
         n_al++;
         if (o_power !== ap) bad_pw++;
         if (o_step_trigger) bad_tr++;
         if (o_force_step_trigger) n_ft++;
         if (o_force_step_value !== 3'd0 || o_force_substep !== 4'd0) bad_fv++;
         tick();
      end
      checks++;
      if (n_al !== 5) begin failures++; $display("FAIL align_len: got %0d expected 5", n_al); end
      checks++;
      if (n_ft !== 1) begin failures++; $display("FAIL force_trig_cycles: got %0d expected 1", n_ft); end
      checks++;
      if (bad_pw !== 0 || bad_tr !== 0 || bad_fv !== 0) begin
         failures++;
         $display("FAIL align_outputs: got pw_err=%0d trig=%0d fv_err=%0d expected 0 0 0", bad_pw, bad_tr, bad_fv);
      end
      checks++;
      if (o_state !== 3'd2 || o_power !== rp) begin
         failures++;
         $display("FAIL ramp_entry: got state=%0d power=%0d expected 2 7", o_state, o_power);
      end
      entry = cyc;
      trig_t.delete();
      collect(30, 2000);
      checks++;
      if (trig_t.size() != 30 || o_state !== 3'd2) begin
         failures++;
         $display("FAIL ramp_30_trigs: got n=%0d state=%0d expected 30 2", trig_t.size(), o_state);
      end
      tick();
      checks++;
      if (o_state !== 3'd3 || o_running !== 1'b1) begin
         failures++;
         $display("FAIL ramp_to_run: got state=%0d running=%0b expected 3 1", o_state, o_running);
      end
      collect(40, 500);
      checks++;
      if (trig_t.size() != 40) begin
         failures++;
         $display("FAIL ramp_trig_count: got %0d expected 40", trig_t.size());
      end
      for (int g = 0; g < 4; g++) bad_g[g] = 0;
      prev = entry;
      for (int i = 0; i < trig_t.size(); i++) begin
         exp_iv = (i < 10) ? 20 : (i < 20) ? 16 : (i < 30) ? 12 : 8;
         d = trig_t[i] - prev;
         if (d != exp_iv) bad_g[i / 10]++;
         prev = trig_t[i];
      end
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (bad_g[g] != 0) begin
            failures++;
            $display("FAIL ramp_period_group%0d: got %0d bad intervals expected 0 (period %0d)", g, bad_g[g], 20 - 4 * g);
         end
      end
      checks++;
      if (o_running !== 1'b1 || o_power !== rp) begin
         failures++;
         $display("FAIL run_status: got running=%0b power=%0d expected 1 7", o_running, o_power);
      end
      stop = 1;
      tick();
      stop = 0;
      checks++;
      if (o_state !== 3'd0 || o_power !== 4'd0 || o_step_trigger !== 1'b0 || o_running !== 1'b0) begin
         failures++;
         $display("FAIL stop_run: got state=%0d power=%0d trig=%0b run=%0b expected 0 0 0 0",
                  o_state, o_power, o_step_trigger, o_running);
      end
   endtask

   task automatic test_direct_run();
      int n_al, entry, prev, bad;
      align_t = 16'd0; sp = 16'd6; tp = 16'd10; dec = 8'd4;
      start = 1;
      tick();
      start = 0;
      n_al = 0;
      while (o_state == 3'd1 && n_al < 100) begin n_al++; tick(); end
      checks++;
      if (n_al !== 1) begin failures++; $display("FAIL align_zero_len: got %0d expected 1", n_al); end
      checks++;
      if (o_state !== 3'd3 || o_running !== 1'b1) begin
         failures++;
         $display("FAIL direct_run: got state=%0d running=%0b expected 3 1", o_state, o_running);
      end
      entry = cyc;
      tp = 16'd3;   // must be ignored once latched
      trig_t.delete();
      collect(3, 200);
      bad = 0;
      prev = entry;
      foreach (trig_t[i]) begin
         if (trig_t[i] - prev != 10) bad++;
         prev = trig_t[i];
      end
      checks++;
      if (trig_t.size() != 3 || bad != 0) begin
         failures++;
         $display("FAIL direct_run_period: got n=%0d bad=%0d expected 3 triggers every 10", trig_t.size(), bad);
      end
      go_idle();
   endtask

   task automatic test_brake_mid_ramp();
      int n_tr, n_bad;
      align_t = 16'd1; sp = 16'd20; tp = 16'd8; dec = 8'd4;
      start = 1;
      tick();
      start = 0;
      tick();
      trig_t.delete();
      collect(3, 200);
      brake = 1;
      tick();
      checks++;
      if (o_state !== 3'd4 || o_brake !== 1'b1 || o_power !== 4'd0 || o_step_trigger !== 1'b0) begin
         failures++;
         $display("FAIL brake_entry: got state=%0d brake=%0b power=%0d trig=%0b expected 4 1 0 0",
                  o_state, o_brake, o_power, o_step_trigger);
      end
      n_tr = 0; n_bad = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (o_step_trigger) n_tr++;
         if (o_state !== 3'd4 || o_brake !== 1'b1) n_bad++;
      end
      checks++;
      if (n_tr != 0 || n_bad != 0) begin
         failures++;
         $display("FAIL brake_hold: got triggers=%0d bad_cycles=%0d expected 0 0", n_tr, n_bad);
      end
      brake = 0;
      tick();
      checks++;
      if (o_state !== 3'd0 || o_brake !== 1'b0) begin
         failures++;
         $display("FAIL brake_release: got state=%0d brake=%0b expected 0 0", o_state, o_brake);
      end
   endtask

   task automatic test_stop_brake_run();
      align_t = 16'd1; sp = 16'd4; tp = 16'd4;
      start = 1;
      tick();
      start = 0;
      tick();
      tick();
      stop = 1; brake = 1;
      tick();
      checks++;
      if (o_state !== 3'd4 || o_brake !== 1'b1) begin
         failures++;
         $display("FAIL stop_brake_run: got state=%0d brake=%0b expected 4 1", o_state, o_brake);
      end
      stop = 0; brake = 0;
      tick();
   endtask

   task automatic test_ramp_dec0();
      int entry, prev, bad;
      int exp_iv;
      align_t = 16'd1; sp = 16'd12; tp = 16'd10; dec = 8'd0;
      start = 1;
      tick();
      start = 0;
      tick();
      entry = cyc;
      trig_t.delete();
      collect(30, 1000);
      bad = 0;
      prev = entry;
      foreach (trig_t[i]) begin
         exp_iv = (i < 10) ? 12 : (i < 20) ? 11 : 10;
         if (trig_t[i] - prev != exp_iv) bad++;
         prev = trig_t[i];
      end
      checks++;
      if (trig_t.size() != 30 || bad != 0) begin
         failures++;
         $display("FAIL ramp_dec0: got n=%0d bad=%0d expected 30 triggers at 12,11,10", trig_t.size(), bad);
      end
      tick();
      checks++;
      if (o_state !== 3'd3) begin failures++; $display("FAIL dec0_run: got state=%0d expected 3", o_state); end
      go_idle();
   endtask

   task automatic test_reset_mid_run();
      align_t = 16'd1; sp = 16'd5; tp = 16'd5;
      start = 1;
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (o_state !== 3'd3) begin failures++; $display("FAIL pre_reset_run: got state=%0d expected 3", o_state); end
      rst_n = 0;
      #1;
      checks++;
      if ({o_state, o_power, o_step_trigger, o_brake, o_running, o_force_step_trigger} !== 13'd0) begin
         failures++;
         $display("FAIL reset_mid_run: got state=%0d power=%0d trig=%0b run=%0b expected all 0",
                  o_state, o_power, o_step_trigger, o_running);
      end
      tick();
      rst_n = 1;
      tick();
      checks++;
      if (o_state !== 3'd1 || o_force_step_trigger !== 1'b1) begin
         failures++;
         $display("FAIL restart_after_reset: got state=%0d ft=%0b expected 1 1", o_state, o_force_step_trigger);
      end
      go_idle();
   endtask

   task automatic test_held_start_priority();
      int n_bad;
      start = 1; stop = 1;
      n_bad = 0;
      for (int i = 0; i < 4; i++) begin tick(); if (o_state !== 3'd0) n_bad++; end
      checks++;
      if (n_bad != 0) begin failures++; $display("FAIL start_with_stop: got %0d non-idle cycles expected 0", n_bad); end
      brake = 1;
      tick();
      checks++;
      if (o_state !== 3'd4) begin failures++; $display("FAIL idle_brake: got state=%0d expected 4", o_state); end
      brake = 0;
      tick(); tick();
      checks++;
      if (o_state !== 3'd0) begin failures++; $display("FAIL brake_release_stop: got state=%0d expected 0", o_state); end
      stop = 0;
      tick();
      checks++;
      if (o_state !== 3'd1) begin failures++; $display("FAIL held_start_align: got state=%0d expected 1", o_state); end
      go_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ramp();
      test_direct_run();
      test_brake_mid_ramp();
      test_stop_brake_run();
      test_ramp_dec0();
      test_reset_mid_run();
      test_held_start_priority();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
